quad_pixel_serializer: RTL

- Receiving end of the shader quad bus: accepts packed 4-pixel RGB quads (R_quad/G_quad/B_quad + valid) from the shader core.
- Buffers quads in a small FIFO and unpacks them into a one-pixel-per-cycle RGB888 stream with ready/valid backpressure.
- Tags each pixel with raster x/y, start-of-frame and end-of-line, for the framebuffer writer / scan-out stage.

---
 rtl/quad_pixel_serializer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/quad_pixel_serializer.sv
// Shader quad bus receiver: buffers packed 4-pixel RGB quads and serialises them
// into a one-pixel-per-cycle RGB888 stream tagged with raster position.
module quad_pixel_serializer #(
  parameter int unsigned BITS_X     = 9,
  parameter int unsigned BITS_Y     = 8,
  parameter int unsigned H_ACTIVE   = 320,
  parameter int unsigned V_ACTIVE   = 240,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   R_quad,
  input  logic [31:0]                   G_quad,
  input  logic [31:0]                   B_quad,
  input  logic                          quad_valid,
  output logic                          quad_space,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    pix_r,
  output logic [7:0]                    pix_g,
  output logic [7:0]                    pix_b,
  output logic [BITS_X-1:0]             pix_x,
  output logic [BITS_Y-1:0]             pix_y,
  output logic                          pix_sof,
  output logic                          pix_eol,
  output logic                          pix_valid,
  input  logic                          pix_ready
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
  } quad_t;

  typedef enum logic {S_IDLE, S_ACTIVE} state_e;

  quad_t             mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              space_q, space_d;
  logic              ovf_q, ovf_d;
  state_e            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  quad_t             hold_q, hold_d;
  logic [BITS_X-1:0] x_q, x_d;
  logic [BITS_Y-1:0] y_q, y_d;
  logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
  logic              sof_q, sof_d, eol_q, eol_d, valid_q, valid_d;

  logic full_c, empty_c, push_c, pop_c, hs_c;

  // Lane 0 is the most significant byte of the quad.
  function automatic logic [7:0] lane_byte(input logic [31:0] q, input logic [1:0] l);
    case (l)
      2'd0:    return q[31:24];
      2'd1:    return q[23:16];
      2'd2:    return q[15:8];
      default: return q[7:0];
    endcase
  endfunction

  // FIFO storage needs no reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= '{r: R_quad, g: G_quad, b: B_quad};
  end

  always_comb begin
    full_c   = (level_q == LW'(FIFO_DEPTH));
    empty_c  = (level_q == '0);
    push_c   = quad_valid && !full_c;
    hs_c     = valid_q && pix_ready;
    pop_c    = 1'b0;
    state_d  = state_q;
    lane_d   = lane_q;
    hold_d   = hold_q;

    case (state_q)
      S_IDLE: begin
        if (!empty_c) pop_c = 1'b1;
      end
      S_ACTIVE: begin
        if (hs_c) begin
          if (lane_q != 2'd3) begin
            lane_d = lane_q + 2'd1;
          end else if (!empty_c) begin
            pop_c = 1'b1;
          end else begin
            state_d = S_IDLE;
            lane_d  = 2'd0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop_c) begin
      hold_d  = mem_q[rd_ptr_q];
      lane_d  = 2'd0;
      state_d = S_ACTIVE;
    end

    wr_ptr_d = push_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    space_d = (level_d != LW'(FIFO_DEPTH));
    ovf_d   = ovf_q || (quad_valid && full_c);

    x_d = x_q;
    y_d = y_q;
    if (hs_c) begin
      if (x_q == BITS_X'(H_ACTIVE - 1)) begin
        x_d = '0;
        y_d = (y_q == BITS_Y'(V_ACTIVE - 1)) ? '0 : y_q + BITS_Y'(1);
      end else begin
        x_d = x_q + BITS_X'(1);
      end
    end

    r_d     = lane_byte(hold_d.r, lane_d);
    g_d     = lane_byte(hold_d.g, lane_d);
    b_d     = lane_byte(hold_d.b, lane_d);
    sof_d   = (x_d == '0) && (y_d == '0);
    eol_d   = (x_d == BITS_X'(H_ACTIVE - 1));
    valid_d = (state_d == S_ACTIVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      space_q  <= 1'b1;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      lane_q   <= 2'd0;
      hold_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      sof_q    <= 1'b1;
      eol_q    <= (H_ACTIVE == 1);
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      space_q  <= space_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      lane_q   <= lane_d;
      hold_q   <= hold_d;
      x_q      <= x_d;
      y_q      <= y_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      sof_q    <= sof_d;
      eol_q    <= eol_d;
      valid_q  <= valid_d;
    end
  end

  assign quad_space = space_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign pix_r      = r_q;
  assign pix_g      = g_q;
  assign pix_b      = b_q;
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign pix_sof    = sof_q;
  assign pix_eol    = eol_q;
  assign pix_valid  = valid_q;

endmodule
